// File: rtl/single_unit_rr_arbiter_if.sv
// Requester-side channels of the shared-unit arbiter: one request and one
// response valid/ready pair per requester, with flat 32-bit data lanes.
interface single_unit_rr_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ-1:0]    rsp_valid;
   logic [32*N_REQ-1:0] rsp_data;
   logic [N_REQ-1:0]    rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/single_unit_rr_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable unit among N_REQ
// requesters; a tag pipeline routes each result to its owner's response buffer.
module single_unit_rr_arbiter #(
   parameter int N_REQ   = 4,
   parameter int LATENCY = 1,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   single_unit_rr_arbiter_if.slave req_if,
   output logic                    unit_in_valid,
   output logic [31:0]             unit_a,
   input  logic                    unit_out_valid,
   input  logic [31:0]             unit_c,
   output logic                    err
);
   localparam int GW = $clog2(LATENCY + 2);

   logic [N_REQ-1:0]    inflight;
   logic [N_REQ-1:0]    rsp_valid_q;
   logic [32*N_REQ-1:0] rsp_data_q;
   logic [N_REQ-1:0]    busy;
   logic [N_REQ-1:0]    eligible;
   logic [N_REQ-1:0]    grant;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     win_id;
   logic                win_found;
   logic [31:0]         win_data;
   logic [ID_W:0]       scan_idx;
   logic [LATENCY:0]    tag_v;
   logic [ID_W-1:0]     tag_id [LATENCY+1];
   logic [GW-1:0]       guard;
   logic                guard_done;
   logic                cap_en;
   logic [ID_W-1:0]     cap_id;

   // Busy uses only registered state, so a pop this cycle frees the slot next cycle.
   assign busy       = inflight | rsp_valid_q;
   assign eligible   = req_if.req_valid & ~busy;
   assign guard_done = (guard == '0);
   assign cap_en     = guard_done & unit_out_valid & tag_v[LATENCY];
   assign cap_id     = tag_id[LATENCY];

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int off = 0; off < N_REQ; off++) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
         if (scan_idx >= (ID_W+1)'(N_REQ))
            scan_idx = scan_idx - (ID_W+1)'(N_REQ);
         if (!win_found && eligible[scan_idx[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      grant    = '0;
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_found && win_id == ID_W'(i)) begin
            grant[i] = 1'b1;
            win_data = req_if.req_data[32*i +: 32];
         end
      end
   end

   assign req_if.req_ready = grant;
   assign req_if.rsp_valid = rsp_valid_q;
   assign req_if.rsp_data  = rsp_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_in_valid <= 1'b0;
         unit_a        <= '0;
         rr_ptr        <= '0;
         inflight      <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
         err           <= 1'b0;
         tag_v         <= '0;
         guard         <= GW'(LATENCY + 1);
         for (int s = 0; s <= LATENCY; s++)
            tag_id[s] <= '0;
      end else begin
         unit_in_valid <= win_found;
         if (win_found) begin
            unit_a <= win_data;
            rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
         end

         tag_v[0]  <= win_found;
         tag_id[0] <= win_id;
         for (int s = 1; s <= LATENCY; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end

         if (!guard_done)
            guard <= guard - GW'(1);

         for (int i = 0; i < N_REQ; i++) begin
            if (win_found && win_id == ID_W'(i))
               inflight[i] <= 1'b1;
            else if (cap_en && cap_id == ID_W'(i))
               inflight[i] <= 1'b0;

            // Capture takes priority over a same-cycle pop; that collision is flagged below.
            if (cap_en && cap_id == ID_W'(i)) begin
               rsp_valid_q[i]         <= 1'b1;
               rsp_data_q[32*i +: 32] <= unit_c;
            end else if (rsp_valid_q[i] && req_if.rsp_ready[i]) begin
               rsp_valid_q[i] <= 1'b0;
            end
         end

         if (guard_done && (unit_out_valid != tag_v[LATENCY]))
            err <= 1'b1;
         if (cap_en && rsp_valid_q[cap_id])
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_single_unit_rr_arbiter.sv
// Directed bench: DUT a (N_REQ=4, LATENCY=1) and DUT b (N_REQ=4, LATENCY=3),
// each fed by a behavioural shared-unit model that is never reset.
module tb_single_unit_rr_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n, rst_b_n;
   logic uiv_a, uov_a, err_a, uiv_b, uov_b, err_b;
   logic [31:0] ua_a, uc_a, ua_b, uc_b;

   single_unit_rr_arbiter_if #(.N_REQ(N)) ifa ();
   single_unit_rr_arbiter_if #(.N_REQ(N)) ifb ();

   single_unit_rr_arbiter #(.N_REQ(N), .LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .req_if(ifa),
      .unit_in_valid(uiv_a), .unit_a(ua_a),
      .unit_out_valid(uov_a), .unit_c(uc_a), .err(err_a)
   );

   single_unit_rr_arbiter #(.N_REQ(N), .LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .req_if(ifb),
      .unit_in_valid(uiv_b), .unit_a(ua_b),
      .unit_out_valid(uov_b), .unit_c(uc_b), .err(err_b)
   );

   // Stand-in for the shared unit: log2 for the directed operands, bit-invert otherwise.
   function automatic logic [31:0] unit_fn(input logic [31:0] a);
      case (a)
         32'h4100_0000: unit_fn = 32'h4040_0000;
         32'h3F00_0000: unit_fn = 32'hBF80_0000;
         32'h4180_0000: unit_fn = 32'h4080_0000;
         default:       unit_fn = ~a;
      endcase
   endfunction

   logic [7:0]  ma_v = '0;
   logic [7:0]  mb_v = '0;
   logic [31:0] ma_d [8] = '{default: '0};
   logic [31:0] mb_d [8] = '{default: '0};
   logic        inj_a = 1'b0;
   logic [2:0]  tap_b = 3'd2;

   always @(posedge clk) begin
      ma_v    <= {ma_v[6:0], uiv_a};
      mb_v    <= {mb_v[6:0], uiv_b};
      ma_d[0] <= ua_a;
      mb_d[0] <= ua_b;
      for (int i = 1; i < 8; i++) begin
         ma_d[i] <= ma_d[i-1];
         mb_d[i] <= mb_d[i-1];
      end
   end

   assign uov_a = ma_v[0] | inj_a;
   assign uc_a  = unit_fn(ma_d[0]);
   assign uov_b = mb_v[tap_b];
   assign uc_b  = unit_fn(mb_d[tap_b]);

   int checks   = 0;
   int failures = 0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   task automatic reset_a();
      rst_a_n = 1'b0;
      ifa.req_valid = '0;
      ifa.rsp_ready = '0;
      inj_a = 1'b0;
      idle(2);
      rst_a_n = 1'b1;
      idle(4);
   endtask

   task automatic test_reset();
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      ifa.req_valid = '0;
      ifb.req_valid = '0;
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0000", ifa.rsp_valid); end
      checks++; if (ifa.rsp_data !== 128'h0) begin failures++; $display("FAIL reset_rsp_data: got %h want 0", ifa.rsp_data); end
      checks++; if (uiv_a !== 1'b0 || ua_a !== 32'h0) begin failures++; $display("FAIL reset_unit: got v=%b a=%h want v=0 a=0", uiv_a, ua_a); end
      checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin failures++; $display("FAIL reset_err: got a=%b b=%b want 0", err_a, err_b); end
      checks++; if (ifa.req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready: got %b want 0000", ifa.req_ready); end
      next_cycle();
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      idle(6);
      @(negedge clk);
      checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin failures++; $display("FAIL idle_err: got a=%b b=%b want 0", err_a, err_b); end
   endtask

   task automatic test_single_request();
      next_cycle();
      ifa.req_valid = 4'b0001;
      ifa.req_data[31:0] = 32'h4100_0000;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", ifa.req_ready); end
      next_cycle();
      ifa.req_valid = '0;
      @(negedge clk);
      checks++; if (uiv_a !== 1'b1 || ua_a !== 32'h4100_0000) begin failures++; $display("FAIL single_issue: got v=%b a=%h want v=1 a=41000000", uiv_a, ua_a); end
      next_cycle();
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0) begin failures++; $display("FAIL single_early: got %b want 0000", ifa.rsp_valid); end
      next_cycle();
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0001 || ifa.rsp_data[31:0] !== 32'h4040_0000) begin failures++; $display("FAIL single_rsp: got v=%b d=%h want v=0001 d=40400000", ifa.rsp_valid, ifa.rsp_data[31:0]); end
      next_cycle();
      ifa.rsp_ready = 4'b0001;
      next_cycle();
      ifa.rsp_ready = '0;
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0 || ifa.rsp_data[31:0] !== 32'h4040_0000) begin failures++; $display("FAIL single_pop: got v=%b d=%h want v=0000 d=40400000", ifa.rsp_valid, ifa.rsp_data[31:0]); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      reset_a();
      for (int i = 0; i < N; i++) ifa.req_data[32*i +: 32] = 32'h1000_0000 + i;
      ifa.rsp_ready = 4'b1111;
      ifa.req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         exp_g = 4'b0001 << (k % 4);
         @(negedge clk);
         checks++; if (ifa.req_ready !== exp_g) begin failures++; $display("FAIL rr_grant_%0d: got %b want %b", k, ifa.req_ready, exp_g); end
         next_cycle();
      end
      ifa.req_valid = '0;
      idle(6);
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0 || err_a !== 1'b0) begin failures++; $display("FAIL rr_drain: got v=%b err=%b want 0000 0", ifa.rsp_valid, err_a); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ifa.rsp_data[32*i +: 32] !== unit_fn(32'h1000_0000 + i)) begin
            failures++;
            $display("FAIL rr_route_%0d: got %h want %h", i, ifa.rsp_data[32*i +: 32], unit_fn(32'h1000_0000 + i));
         end
      end
   endtask

   task automatic test_busy_gating();
      ifa.rsp_ready = '0;
      next_cycle();
      ifa.req_valid = 4'b0100;
      ifa.req_data[95:64] = 32'h4180_0000;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b0100) begin failures++; $display("FAIL busy_first_grant: got %b want 0100", ifa.req_ready); end
      next_cycle();
      ifa.req_data[95:64] = 32'h1234_5678;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if (ifa.req_ready !== 4'b0) begin failures++; $display("FAIL busy_held_%0d: got %b want 0000", k, ifa.req_ready); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0100 || ifa.rsp_data[95:64] !== 32'h4080_0000) begin failures++; $display("FAIL busy_rsp: got v=%b d=%h want 0100 40800000", ifa.rsp_valid, ifa.rsp_data[95:64]); end
      next_cycle();
      ifa.rsp_ready = 4'b0100;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b0) begin failures++; $display("FAIL busy_same_cycle: got %b want 0000", ifa.req_ready); end
      next_cycle();
      ifa.rsp_ready = '0;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b0100 || ifa.rsp_valid !== 4'b0) begin failures++; $display("FAIL busy_next_cycle: got r=%b v=%b want 0100 0000", ifa.req_ready, ifa.rsp_valid); end
      next_cycle();
      ifa.req_valid = '0;
      idle(3);
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0100 || ifa.rsp_data[95:64] !== 32'hEDCB_A987) begin failures++; $display("FAIL busy_second_rsp: got v=%b d=%h want 0100 edcba987", ifa.rsp_valid, ifa.rsp_data[95:64]); end
      next_cycle();
      ifa.rsp_ready = 4'b0100;
      next_cycle();
      ifa.rsp_ready = '0;
   endtask

   task automatic test_interleave();
      reset_a();
      ifa.req_valid = 4'b0010;
      ifa.req_data[63:32] = 32'h3F00_0000;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b0010) begin failures++; $display("FAIL il_grant1: got %b want 0010", ifa.req_ready); end
      next_cycle();
      ifa.req_valid = 4'b1000;
      ifa.req_data[127:96] = 32'h4180_0000;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b1000) begin failures++; $display("FAIL il_grant3: got %b want 1000", ifa.req_ready); end
      next_cycle();
      ifa.req_valid = '0;
      next_cycle();
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0010 || ifa.rsp_data[63:32] !== 32'hBF80_0000) begin failures++; $display("FAIL il_rsp1: got v=%b d=%h want 0010 bf800000", ifa.rsp_valid, ifa.rsp_data[63:32]); end
      next_cycle();
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b1010 || ifa.rsp_data[127:96] !== 32'h4080_0000 || ifa.rsp_data[63:32] !== 32'hBF80_0000) begin
         failures++; $display("FAIL il_rsp3: got v=%b d3=%h d1=%h want 1010 40800000 bf800000", ifa.rsp_valid, ifa.rsp_data[127:96], ifa.rsp_data[63:32]);
      end
      next_cycle();
      ifa.rsp_ready = 4'b1010;
      next_cycle();
      ifa.rsp_ready = '0;
      @(negedge clk);
      checks++; if (ifa.rsp_valid !== 4'b0 || err_a !== 1'b0) begin failures++; $display("FAIL il_pop: got v=%b err=%b want 0000 0", ifa.rsp_valid, err_a); end
   endtask

   task automatic test_reset_midflight();
      next_cycle();
      ifa.req_valid = 4'b0001;
      ifa.req_data[31:0] = 32'h4100_0000;
      @(negedge clk);
      checks++; if (ifa.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_grant: got %b want 0001", ifa.req_ready); end
      next_cycle();
      rst_a_n = 1'b0;
      ifa.req_valid = '0;
      @(negedge clk);
      checks++; if (uiv_a !== 1'b0) begin failures++; $display("FAIL mid_uiv: got %b want 0", uiv_a); end
      idle(3);
      rst_a_n = 1'b1;
      next_cycle();
      inj_a = 1'b1;
      next_cycle();
      inj_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (ifa.rsp_valid !== 4'b0 || err_a !== 1'b0) begin failures++; $display("FAIL mid_quiet_%0d: got v=%b err=%b want 0000 0", k, ifa.rsp_valid, err_a); end
         next_cycle();
      end
      inj_a = 1'b1;
      next_cycle();
      inj_a = 1'b0;
      @(negedge clk);
      checks++; if (err_a !== 1'b1 || ifa.rsp_valid !== 4'b0) begin failures++; $display("FAIL mid_spurious: got err=%b v=%b want 1 0000", err_a, ifa.rsp_valid); end
      reset_a();
   endtask

   task automatic test_latency3();
      ifb.req_valid = 4'b0001;
      ifb.req_data[31:0] = 32'h4100_0000;
      @(negedge clk);
      checks++; if (ifb.req_ready !== 4'b0001) begin failures++; $display("FAIL l3_grant: got %b want 0001", ifb.req_ready); end
      next_cycle();
      ifb.req_valid = '0;
      @(negedge clk);
      checks++; if (uiv_b !== 1'b1 || ua_b !== 32'h4100_0000) begin failures++; $display("FAIL l3_issue: got v=%b a=%h want 1 41000000", uiv_b, ua_b); end
      idle(3);
      @(negedge clk);
      checks++; if (ifb.rsp_valid !== 4'b0) begin failures++; $display("FAIL l3_early: got %b want 0000", ifb.rsp_valid); end
      next_cycle();
      @(negedge clk);
      checks++; if (ifb.rsp_valid !== 4'b0001 || ifb.rsp_data[31:0] !== 32'h4040_0000 || err_b !== 1'b0) begin
         failures++; $display("FAIL l3_rsp: got v=%b d=%h err=%b want 0001 40400000 0", ifb.rsp_valid, ifb.rsp_data[31:0], err_b);
      end
      next_cycle();
      ifb.rsp_ready = 4'b0001;
      next_cycle();
      ifb.rsp_ready = '0;
      tap_b = 3'd1;
      next_cycle();
      ifb.req_valid = 4'b0001;
      ifb.req_data[31:0] = 32'h4180_0000;
      next_cycle();
      ifb.req_valid = '0;
      idle(6);
      @(negedge clk);
      checks++; if (err_b !== 1'b1 || ifb.rsp_valid !== 4'b0) begin failures++; $display("FAIL l3_short_latency: got err=%b v=%b want 1 0000", err_b, ifb.rsp_valid); end
   endtask

   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      ifa.req_valid = '0; ifa.req_data = '0; ifa.rsp_ready = '0;
      ifb.req_valid = '0; ifb.req_data = '0; ifb.rsp_ready = '0;
      test_reset();
      test_single_request();
      test_round_robin();
      test_busy_gating();
      test_interleave();
      test_reset_midflight();
      test_latency3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/single_unit_rr_arbiter.md
Name: single_unit_rr_arbiter

Overview:
- Shares one fixed-latency, non-stallable single-precision unit among N_REQ requesters, for example single_base2_exp with latency 1.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin and issued to the unit through a registered stage.
- A tag pipeline tracks each operation's owner, and each result is routed to that owner's one-entry response buffer.
- Each requester may have at most one operation in flight or unread, so the unit never needs backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LATENCY, 1, unit cycles from in_valid to out_valid (1..8).
- ID_W, $clog2(N_REQ), requester index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_data  in  32*N_REQ  operand; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  grant; at most one bit high per cycle.
- rsp_valid  out  N_REQ  result available.
- rsp_data  out  32*N_REQ  result for each requester.
- rsp_ready  in  N_REQ  result consumed.
- unit_in_valid  out  1  to the shared unit's in_valid.
- unit_a  out  32  to the shared unit's operand a.
- unit_out_valid  in  1  from the shared unit.
- unit_c  in  32  from the shared unit.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, clk-synchronous deassert use) clears all of the following:
  - unit_in_valid=0, unit_a=0.
  - rsp_valid=0, rsp_data=0.
  - err=0, rr_ptr=0.
  - in-flight flags and tag pipeline all 0.
  - guard counter loaded to LATENCY+1.
- busy[i] = inflight[i] | rsp_valid[i].
- eligible[i] = req_valid[i] & ~busy[i].
- Grant selection is combinational. The winner is the first eligible index scanning rr_ptr, rr_ptr+1, … modulo N_REQ. req_ready[winner]=1; all other req_ready bits are 0. No eligible requester means req_ready=0.
- req_ready must not depend on rsp_ready in the same cycle. A requester whose buffer is popped in cycle t becomes eligible in cycle t+1, never t.
- Handshake for requester w in cycle t:
  - at the edge ending t: unit_a<=req_data[w], unit_in_valid<=1, inflight[w]<=1, tag stage 0<={1,w}, rr_ptr<=(w+1) mod N_REQ.
  - With no handshake: unit_in_valid<=0, unit_a holds, rr_ptr holds.
- Tag pipeline has LATENCY+1 stages of {valid, id}, advancing every cycle. The final stage is aligned with unit_out_valid: for a handshake in cycle t, unit_in_valid is high in t+1 and unit_out_valid in t+1+LATENCY.
- Result capture: when unit_out_valid=1 and the final tag is valid with id k:
  - rsp_data[k]<=unit_c, rsp_valid[k]<=1, inflight[k]<=0.
  - rsp_valid[k] is high from cycle t+2+LATENCY.
- Response pop: rsp_valid[i] & rsp_ready[i] clears rsp_valid[i] at the edge. rsp_data[i] holds its value.
- Capture and pop cannot coincide for the same i, because busy gating guarantees it. If they do coincide, capture wins and err<=1.
- Errors, all of which set err sticky until reset:
  - unit_out_valid=1 with the final tag invalid.
  - the final tag valid with unit_out_valid=0.
  - capture to a requester whose rsp_valid=1.
- Guard counter: decrements to 0 after reset. While nonzero, unit_out_valid is ignored and no error is raised. This covers stale output from the unreset unit.
- Reset mid-operation: all in-flight work is discarded. No response is ever produced for operations issued before reset.
- Throughput: one issue per cycle when distinct requesters are eligible. Per-requester rate is at most one operation per LATENCY+3 cycles.
- No combinational path from unit_c or unit_out_valid to any output.

Test Plan:
- Single request:
  - Stimulus: N_REQ=4, LATENCY=1; req_valid=0001, req_data[0]=0x41000000 (8.0) in cycle 5.
  - Response: req_ready=0001 in cycle 5; unit_in_valid=1 and unit_a=0x41000000 in cycle 6.
  - With the bench model returning 0x40400000 in cycle 7: rsp_valid[0]=1 and rsp_data[0]=0x40400000 in cycle 8.
- Round-robin: all four req_valid held high with responses popped immediately -> grants in order 0,1,2,3, then 0 again after requester 0 frees. No index is granted twice while another eligible requester waits.
- Busy gating:
  - Stimulus: requester 2 holds req_valid with rsp_ready=0.
  - Response: after the first result, req_ready[2] stays 0 and rsp_data[2] is stable.
  - Raising rsp_ready[2] in cycle t -> req_ready[2] can assert in t+1, not t.
- Routing under interleave: back-to-back issues to requesters 1 then 3 (operands 0x3F000000, 0x41800000) -> results 0xBF800000 to rsp_data[1] and 0x40800000 to rsp_data[3], one cycle apart, with no swap.
- Reset mid-flight:
  - Stimulus: drop rst_n the cycle after a grant; the model emits unit_out_valid one cycle after release.
  - Response: no rsp_valid and err=0. After the guard expires, a spurious unit_out_valid sets err=1.
- LATENCY=3 build: repeat the single-request scenario -> rsp_valid in cycle t+5. A model delivering at latency 2 sets err.
